zero_detector: RTL and testbench

ZERO_DETECTOR -- requirements
Module: zero_detector

---
 rtl/zero_detector.sv | 128 ++++++++++++
 tb/tb_zero_detector.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/zero_detector.sv
// 64-bit zero detector with optional leading-zero count (enabled by ZERO_DETECTOR_LZC_EN).
// Latency: two register stages (nibble flags, then reduction); one operand per cycle.
// Backpressure: none; each result is valid only in its out_valid cycle.
module zero_detector (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] in,
    input  logic        in_valid,
    output logic        out,
    output logic        out_valid,
    output logic [6:0]  lz_count
);

    // Stage 1: per-nibble zero flags, captured only for qualified operands
    logic [15:0] grp_zero_d, grp_zero_q;
    logic        vld1_d, vld1_q;

    // Stage 2: reduced result, held while no new operand arrives
    logic        out_d, out_q;
    logic        out_vld_d, out_vld_q;

    always_comb begin
        vld1_d     = in_valid;
        grp_zero_d = grp_zero_q;
        if (in_valid) begin
            for (int g = 0; g < 16; g++) begin
                grp_zero_d[g] = (in[4*g +: 4] == 4'h0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grp_zero_q <= '0;
            vld1_q     <= 1'b0;
        end else begin
            grp_zero_q <= grp_zero_d;
            vld1_q     <= vld1_d;
        end
    end

    always_comb begin
        out_vld_d = vld1_q;
        out_d     = out_q;
        if (vld1_q) begin
            out_d = &grp_zero_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q     <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_vld_q;

`ifdef ZERO_DETECTOR_LZC_EN
    function automatic logic [2:0] nib_lz(input logic [3:0] n);
        logic [2:0] r;
        casez (n)
            4'b1???: r = 3'd0;
            4'b01??: r = 3'd1;
            4'b001?: r = 3'd2;
            4'b0001: r = 3'd3;
            default: r = 3'd4;
        endcase
        return r;
    endfunction

    logic [15:0][2:0] grp_lz_d, grp_lz_q;
    logic [6:0]       lz_sum;
    logic             found;
    logic [6:0]       lz_d, lz_q;

    always_comb begin
        grp_lz_d = grp_lz_q;
        if (in_valid) begin
            for (int g = 0; g < 16; g++) begin
                grp_lz_d[g] = nib_lz(in[4*g +: 4]);
            end
        end
    end

    // Walk nibbles from the MSB end; an all-zero word sums to 64
    always_comb begin
        lz_sum = 7'd0;
        found  = 1'b0;
        for (int g = 15; g >= 0; g--) begin
            if (!found) begin
                if (grp_zero_q[g]) begin
                    lz_sum = lz_sum + 7'd4;
                end else begin
                    lz_sum = lz_sum + {4'b0000, grp_lz_q[g]};
                    found  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        lz_d = lz_q;
        if (vld1_q) begin
            lz_d = lz_sum;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grp_lz_q <= '0;
            lz_q     <= 7'd0;
        end else begin
            grp_lz_q <= grp_lz_d;
            lz_q     <= lz_d;
        end
    end

    assign lz_count = lz_q;
`else
    assign lz_count = 7'd0;
`endif

endmodule

// File: tb/tb_zero_detector.sv
// Directed-vector bench for zero_detector; lz_count expectations follow ZERO_DETECTOR_LZC_EN.
module tb_zero_detector;

`ifdef ZERO_DETECTOR_LZC_EN
    localparam bit LZC = 1'b1;
`else
    localparam bit LZC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in_dat;
    logic        in_valid;
    logic        out;
    logic        out_valid;
    logic [6:0]  lz_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    zero_detector dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in_dat),
        .in_valid  (in_valid),
        .out       (out),
        .out_valid (out_valid),
        .lz_count  (lz_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] exp_lz(input logic [6:0] v);
        return LZC ? v : 7'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single isolated operand: result appears after the second edge, for one cycle, then holds
    task automatic run_one(input string tag, input logic [63:0] v, input logic eo, input logic [6:0] elz);
        in_dat   = v;
        in_valid = 1'b1;
        tick();
        chk({tag, "_vld_early"}, 64'(out_valid), 64'd0);
        in_valid = 1'b0;
        in_dat   = 64'hA5A5_0000_FFFF_0001;
        tick();
        chk({tag, "_vld"}, 64'(out_valid), 64'd1);
        chk({tag, "_out"}, 64'(out), 64'(eo));
        chk({tag, "_lz"},  64'(lz_count), 64'(exp_lz(elz)));
        tick();
        chk({tag, "_vld_drop"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_hold"}, 64'(out), 64'(eo));
        chk({tag, "_lz_hold"},  64'(lz_count), 64'(exp_lz(elz)));
    endtask

    logic [63:0] b2b_v   [4] = '{64'h0, 64'h1, 64'h8000_0000_0000_0000, 64'h0000_0001_0000_0000};
    logic        b2b_out [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [6:0]  b2b_lz  [4] = '{7'd64, 7'd63, 7'd0, 7'd31};

    initial begin
        int pulses;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_dat   = 64'h0;
        #12;
        chk("rst_out", 64'(out), 64'd0);
        chk("rst_vld", 64'(out_valid), 64'd0);
        chk("rst_lz",  64'(lz_count), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        run_one("zero",     64'h0000_0000_0000_0000, 1'b1, 7'd64);
        run_one("ones",     64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 7'd0);
        run_one("bit40_0",  64'hFFFF_FEFF_FFFF_FFFF, 1'b0, 7'd0);
        run_one("bit4",     64'h0000_0000_0000_0010, 1'b0, 7'd59);
        run_one("bit58",    64'h0500_0000_0000_0000, 1'b0, 7'd5);

        // Back-to-back operands, one result per cycle
        for (int k = 0; k < 5; k++) begin
            if (k < 4) begin
                in_dat   = b2b_v[k];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (k == 0) begin
                chk("b2b_vld_early", 64'(out_valid), 64'd0);
            end else begin
                chk($sformatf("b2b%0d_vld", k-1), 64'(out_valid), 64'd1);
                chk($sformatf("b2b%0d_out", k-1), 64'(out), 64'(b2b_out[k-1]));
                chk($sformatf("b2b%0d_lz", k-1),  64'(lz_count), 64'(exp_lz(b2b_lz[k-1])));
            end
        end
        tick();
        chk("b2b_vld_end", 64'(out_valid), 64'd0);

        // Reset with an operand in flight: outputs clear at once and the operand vanishes
        in_dat   = 64'h0;
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        chk("pre_rst_out", 64'(out), 64'd1);
        chk("pre_rst_lz",  64'(lz_count), 64'(exp_lz(7'd64)));
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_out", 64'(out), 64'd0);
        chk("mid_rst_vld", 64'(out_valid), 64'd0);
        chk("mid_rst_lz",  64'(lz_count), 64'd0);
        #4;
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (out_valid) pulses++;
        end
        chk("post_rst_pulses", 64'(pulses), 64'd0);

        run_one("after_rst", 64'h8000_0000_0000_0000, 1'b0, 7'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
